// File: rtl/vga_pkg.sv
// Shared 640x480 @ 60 Hz VGA timing constants. Renderers and the compositor
// import these so everyone agrees on where the visible area and sync pulses are.
package vga_pkg;

    localparam int COORD_W      = 10;

    localparam int CLK_DIV_DEF  = 4;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Sync windows are half-open: [start, end)
    localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
    localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: one registered strobe every DIV clocks. stb_next is
// the value stb will take at the next edge, so downstream registers can
// update in the same edge that raises stb.
module clk_en_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic stb_next,
    output logic stb
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          stb_q, stb_d;

    // Count 0..DIV-1; the strobe is high in the cycle the counter has wrapped to 0
    always_comb begin
        stb_d     = (div_cnt_q == CNT_LAST);
        div_cnt_d = stb_d ? '0 : div_cnt_q + CW'(1);
    end

    // Divider state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            stb_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            stb_q     <= stb_d;
        end
    end

    assign stb_next = stb_d;
    assign stb      = stb_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA scan generator: pixel strobe, x/y scan position, active-low syncs,
// visible-area flag and line/frame start pulses. All outputs are registered
// and decoded from the next-state counters, so they line up with x/y exactly.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pix_stb,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST       = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST       = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS        = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS        = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] H_SYNC_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] H_SYNC_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] V_SYNC_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] V_SYNC_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic pix_tick;

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               active_q, active_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;

    clk_en_div #(
        .DIV(CLK_DIV)
    ) u_pix_div (
        .clk      (clk),
        .reset    (reset),
        .stb_next (pix_tick),
        .stb      (pix_stb)
    );

    // Next scan position plus decodes taken from that next position
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_tick) begin
            if (x_q == H_LAST) begin
                x_d          = '0;
                line_start_d = 1'b1;
                if (y_q == V_LAST) begin
                    y_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + COORD_W'(1);
                end
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end
        hsync_d  = !((x_d >= H_SYNC_START) && (x_d < H_SYNC_END));
        vsync_d  = !((y_d >= V_SYNC_START) && (y_d < V_SYNC_END));
        active_d = (x_d < H_VIS) && (y_d < V_VIS);
    end

    // Scan and decode registers; reset puts the beam at the top-left visible pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance and a shrunken-geometry
// instance (CLK_DIV=2, 16x12 scan) so whole frames fit in a short run.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    logic       pix_stb_a, hsync_a, vsync_a, active_a, line_start_a, frame_start_a;
    logic [9:0] x_a, y_a;
    logic       pix_stb_b, hsync_b, vsync_b, active_b, line_start_b, frame_start_b;
    logic [9:0] x_b, y_b;

    vga_sync_gen u_dut_a (
        .clk         (clk),
        .reset       (rst_a),
        .pix_stb     (pix_stb_a),
        .x           (x_a),
        .y           (y_a),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .active      (active_a),
        .line_start  (line_start_a),
        .frame_start (frame_start_a)
    );

    vga_sync_gen #(
        .CLK_DIV  (2),
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (6),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (2)
    ) u_dut_b (
        .clk         (clk),
        .reset       (rst_b),
        .pix_stb     (pix_stb_b),
        .x           (x_b),
        .y           (y_b),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .active      (active_b),
        .line_start  (line_start_b),
        .frame_start (frame_start_b)
    );

    // {pix_stb, x, y, hsync, vsync, active, line_start, frame_start}
    logic [25:0] vec_a, vec_b;
    assign vec_a = {pix_stb_a, x_a, y_a, hsync_a, vsync_a, active_a, line_start_a, frame_start_a};
    assign vec_b = {pix_stb_b, x_b, y_b, hsync_b, vsync_b, active_b, line_start_b, frame_start_b};

    localparam logic [25:0] RESET_VEC = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Closed-form reference: n = clock edges since reset release
    function automatic logic [25:0] model(input int n, input int div,
                                          input int ha, input int hss, input int hse, input int ht,
                                          input int va, input int vss, input int vse, input int vt);
        int   p, xx, yy;
        logic stb, ls, fs, hs, vs, act;
        if (n == 0) begin
            stb = 1'b0; xx = 0; yy = 0;
        end else begin
            stb = ((n % div) == 0);
            p   = n / div;
            xx  = p % ht;
            yy  = (p / ht) % vt;
        end
        ls  = stb && (xx == 0);
        fs  = ls && (yy == 0);
        hs  = !((xx >= hss) && (xx < hse));
        vs  = !((yy >= vss) && (yy < vse));
        act = (xx < ha) && (yy < va);
        return {stb, xx[9:0], yy[9:0], hs, vs, act, ls, fs};
    endfunction

    logic [25:0] q_a[$];
    logic [25:0] q_b[$];
    int          n_a = 0;
    int          n_b = 0;

    // Push expected outputs for each edge as reset/time stimulus is applied
    always @(posedge clk) begin
        n_a = rst_a ? 0 : n_a + 1;
        n_b = rst_b ? 0 : n_b + 1;
        q_a.push_back(model(n_a, 4, 640, 656, 752, 800, 480, 490, 492, 525));
        q_b.push_back(model(n_b, 2, 8, 10, 13, 16, 6, 8, 10, 12));
    end

    // Pop and compare once the outputs have settled after the edge
    always @(posedge clk) begin
        #1;
        if (q_a.size() == 0) check_eq("sb_a_empty", 32'd1, 32'd0);
        else                 check_eq("sb_a", 32'(vec_a), 32'(q_a.pop_front()));
        if (q_b.size() == 0) check_eq("sb_b_empty", 32'd1, 32'd0);
        else                 check_eq("sb_b", 32'(vec_b), 32'(q_b.pop_front()));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, found, hs_cnt, hs_x, fall_x, ls_cnt, ls_at, prev_act;
        int fs_cnt, fs_at, vs_cnt, vs_xy, vbl_act, max_y, prev_xy, pulses, first_ls;

        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) tick();
        check_eq("a_reset_vals", 32'(vec_a), 32'(RESET_VEC));
        rst_a = 1'b0;

        cnt = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (pix_stb_a) begin cnt = i; break; end
        end
        check_eq("a_first_stb", cnt, 4);

        found = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (line_start_a) begin found = 1; break; end
        end
        check_eq("a_ls_found", found, 1);

        hs_cnt = 0; hs_x = -1; fall_x = -1; ls_cnt = 0; ls_at = -1; prev_act = int'(active_a);
        for (int k = 1; k <= 3200; k++) begin
            tick();
            if (!hsync_a) begin
                hs_cnt++;
                if (hs_x < 0) hs_x = int'(x_a);
            end
            if (prev_act == 1 && !active_a && fall_x < 0) fall_x = int'(x_a);
            prev_act = int'(active_a);
            if (line_start_a) begin ls_cnt++; ls_at = k; end
        end
        check_eq("a_hsync_clks", hs_cnt, 384);
        check_eq("a_hsync_start_x", hs_x, 656);
        check_eq("a_active_fall_x", fall_x, 640);
        check_eq("a_ls_count", ls_cnt, 1);
        check_eq("a_ls_period", ls_at, 3200);

        check_eq("b_reset_vals", 32'(vec_b), 32'(RESET_VEC));
        rst_b = 1'b0;

        found = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pix_stb_b) begin found = 1; break; end
        end
        cnt = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (pix_stb_b) begin cnt = i; break; end
        end
        check_eq("b_stb_period", cnt, 2);

        found = 0; prev_xy = -1;
        for (int i = 0; i < 1000; i++) begin
            prev_xy = int'({x_b, y_b});
            tick();
            if (frame_start_b) begin found = 1; break; end
        end
        check_eq("b_fs_found", found, 1);
        check_eq("b_wrap_prev_xy", prev_xy, int'({10'd15, 10'd11}));
        check_eq("b_wrap_xy", 32'({x_b, y_b}), 32'd0);

        fs_cnt = 0; fs_at = -1; vs_cnt = 0; vs_xy = -1; vbl_act = 0; max_y = 0;
        for (int k = 1; k <= 384; k++) begin
            tick();
            if (frame_start_b) begin fs_cnt++; fs_at = k; end
            if (!vsync_b) begin
                vs_cnt++;
                if (vs_xy < 0) vs_xy = int'({x_b, y_b});
            end
            if (y_b >= 10'd6 && active_b) vbl_act++;
            if (int'(y_b) > max_y) max_y = int'(y_b);
        end
        check_eq("b_frame_period", fs_at, 384);
        check_eq("b_fs_count", fs_cnt, 1);
        check_eq("b_vsync_clks", vs_cnt, 64);
        check_eq("b_vsync_start_xy", vs_xy, int'({10'd0, 10'd8}));
        check_eq("b_vblank_active", vbl_act, 0);
        check_eq("b_max_y", max_y, 11);

        found = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (pix_stb_b && x_b == 10'd5 && y_b == 10'd4) begin found = 1; break; end
        end
        check_eq("b_mid_found", found, 1);
        #2;
        rst_b = 1'b1;
        #1;
        check_eq("b_async_reset", 32'(vec_b), 32'(RESET_VEC));
        pulses = 0;
        repeat (2) begin
            tick();
            if (line_start_b || frame_start_b) pulses++;
        end
        check_eq("b_no_pulse_in_reset", pulses, 0);
        rst_b = 1'b0;

        cnt = -1; first_ls = -1;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            if (line_start_b && first_ls < 0) first_ls = i;
            if (frame_start_b) begin cnt = i; break; end
        end
        check_eq("b_restart_first_ls", first_ls, 32);
        check_eq("b_restart_fs", cnt, 384);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
